// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Latency: n/a (types only).
// Backpressure: n/a.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    function automatic int depth_f(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: walks registers 1..DEPTH-1 zeroing one per cycle.
// Latency: DEPTH-1 cycles from clr_req edge; sb_flush is combinational on the request.
// Backpressure: none; clr_req while busy is ignored.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              sb_flush
);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we   = 1'b0;
        sb_flush = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d  = CLEAR;
                    cnt_d    = ADDR_W'(1);
                    sb_flush = 1'b1;
                end
            end
            CLEAR: begin
                clr_we = 1'b1;
                // Counter wraps to 0 after the last register, leaving it at its reset value.
                cnt_d  = cnt_q + ADDR_W'(1);
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clr_busy = (state_q == CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD comb read ports, ALU/load write ports, load scoreboard, clear engine.
// Latency: reads 0 cycles (optional write bypass); writes visible the cycle after the edge.
// Backpressure: none; writes and sb_set are dropped while a clear is running.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_addr,
    input  logic                     clr_req,
    output logic                     clr_busy
);

    localparam int DEPTH = depth_f(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              sb_flush;
    logic              wa_ok, wb_ok, sb_ok;

    regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_clr (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .sb_flush (sb_flush)
    );

    // Qualified requests: register 0 is hardwired and the clear engine owns the array.
    assign wa_ok = wa_en     && !clr_busy && !rst && (wa_addr     != '0);
    assign wb_ok = wb_en     && !clr_busy && !rst && (wb_addr     != '0);
    assign sb_ok = sb_set_en && !clr_busy && !rst && (sb_set_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wa_ok) mem[wa_addr] <= wa_data;
            // Load port is written last so it wins an address collision.
            if (wb_ok) mem[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else if (sb_flush) begin
            pend <= '0;
        end else begin
            if (wb_ok) pend[wb_addr]     <= 1'b0;
            if (sb_ok) pend[sb_set_addr] <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign addr = rd_addr[g*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem[addr];
            busy = pend[addr];
            if (BYPASS != 0) begin
                if (wb_ok && (wb_addr == addr)) begin
                    data = wb_data;
                    busy = 1'b0;
                end else if (wa_ok && (wa_addr == addr)) begin
                    data = wa_data;
                end
            end
            if (addr == '0) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign rd_data[g*DATA_W +: DATA_W] = data;
        assign rd_busy[g]                  = busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one BYPASS=1 and one BYPASS=0 instance share all inputs.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic        wa_en, wb_en, sb_set_en, clr_req;
    logic [4:0]  wa_addr, wb_addr, sb_set_addr;
    logic [31:0] wa_data, wb_data;
    logic        clr_busy, clr_busy_nb;

    int checks = 0;
    int errs   = 0;
    int cnt;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .clr_req(clr_req), .clr_busy(clr_busy_nb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wa_en = 1'b0; wb_en = 1'b0; sb_set_en = 1'b0; clr_req = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic wa(input logic [4:0] a, input logic [31:0] d);
        wa_en = 1'b1; wa_addr = a; wa_data = d;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        wa_addr = '0; wb_addr = '0; sb_set_addr = '0;
        wa_data = '0; wb_data = '0;
        rd_addr = '0;
        tick();

        // Reset state on every address and both ports.
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a));
            #1;
            chk($sformatf("rst_rd0_a%0d", a), rd_data[31:0], 32'h0);
            chk($sformatf("rst_rd1_a%0d", a), rd_data[63:32], 32'h0);
            chk($sformatf("rst_busy_a%0d", a), 32'(rd_busy), 32'h0);
        end
        chk("rst_clr_busy", 32'(clr_busy), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Dual write collision: port B wins.
        wa(5'd5, 32'h11111111);
        wb(5'd5, 32'h22222222);
        tick();
        idle_in();
        set_rd(5'd5, 5'd0);
        #1;
        chk("collide_r5", rd_data[31:0], 32'h22222222);
        chk("collide_r5_nb", rd_data_nb[31:0], 32'h22222222);

        // Writes to r0 are dropped and r0 is never bypassed.
        wa(5'd0, 32'hAAAA5555);
        set_rd(5'd0, 5'd0);
        #1;
        chk("r0_wa_bypass", rd_data[31:0], 32'h0);
        tick();
        idle_in();
        wb(5'd0, 32'h12345678);
        tick();
        idle_in();
        #1;
        chk("r0_after_writes", rd_data[63:32], 32'h0);

        // Bypass vs. no-bypass on a wa write.
        wa(5'd7, 32'h01234567);
        tick();
        wa(5'd7, 32'hDEADBEEF);
        set_rd(5'd7, 5'd7);
        #1;
        chk("byp_wa_r7", rd_data[31:0], 32'hDEADBEEF);
        chk("nobyp_wa_r7", rd_data_nb[31:0], 32'h01234567);
        tick();
        idle_in();
        #1;
        chk("nobyp_r7_next", rd_data_nb[31:0], 32'hDEADBEEF);

        // Bypass priority: wb over wa on the same address.
        wa(5'd8, 32'h00000001);
        wb(5'd8, 32'h00000002);
        set_rd(5'd0, 5'd8);
        #1;
        chk("byp_prio_r8", rd_data[63:32], 32'h00000002);
        tick();
        idle_in();

        // Scoreboard set, load clear with bypass mask, set-wins collision.
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        tick();
        idle_in();
        set_rd(5'd9, 5'd9);
        #1;
        chk("sb_set_r9", 32'(rd_busy[0]), 32'h1);
        chk("sb_set_r9_nb", 32'(rd_busy_nb[0]), 32'h1);
        wb(5'd9, 32'h00000099);
        #1;
        chk("sb_wb_mask", 32'(rd_busy[0]), 32'h0);
        chk("sb_wb_nomask_nb", 32'(rd_busy_nb[0]), 32'h1);
        tick();
        idle_in();
        #1;
        chk("sb_cleared", 32'(rd_busy[0]), 32'h0);
        chk("sb_cleared_nb", 32'(rd_busy_nb[0]), 32'h0);
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        wb(5'd9, 32'h0000AB09);
        tick();
        idle_in();
        #1;
        chk("sb_set_wins", 32'(rd_busy[1]), 32'h1);
        chk("sb_set_wins_data", rd_data[63:32], 32'h0000AB09);

        // Clear engine.
        for (int i = 1; i < 32; i++) begin
            wa(5'(i), 32'h5A5A0000 | 32'(i));
            tick();
        end
        idle_in();
        sb_set_en = 1'b1; sb_set_addr = 5'd3;
        tick();
        idle_in();
        set_rd(5'd3, 5'd31);
        #1;
        chk("fill_r31", rd_data[63:32], 32'h5A5A001F);
        chk("pend_r3_before", 32'(rd_busy[0]), 32'h1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 1) set_rd(5'd3, 5'd9);
            if (k == 11) set_rd(5'd10, 5'd11);
            if (k == 20) begin
                wa(5'd4, 32'hFFFF0004);
                sb_set_en = 1'b1; sb_set_addr = 5'd4;
                set_rd(5'd4, 5'd0);
            end
            if (k == 21) idle_in();
            #1;
            if (clr_busy) cnt++;
            if (k == 1) begin
                chk("clr_busy_first", 32'(clr_busy), 32'h1);
                chk("clr_pend_r3", 32'(rd_busy[0]), 32'h0);
                chk("clr_pend_r9", 32'(rd_busy[1]), 32'h0);
            end
            if (k == 11) begin
                chk("clr_r10_zeroed", rd_data[31:0], 32'h0);
                chk("clr_r11_pending", rd_data[63:32], 32'h5A5A000B);
            end
            if (k == 20) chk("clr_no_bypass_r4", rd_data[31:0], 32'h0);
            tick();
        end
        chk("clr_busy_cycles", 32'(cnt), 32'd31);
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(a));
            #1;
            chk($sformatf("clr_zero_a%0d", a), rd_data[31:0], 32'h0);
            chk($sformatf("clr_busy_a%0d", a), 32'(rd_busy), 32'h0);
        end

        // Reset in the middle of a clear.
        wa(5'd2, 32'h00000222);
        tick();
        wa(5'd20, 32'h00002020);
        tick();
        wa(5'd31, 32'h00003131);
        tick();
        idle_in();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        set_rd(5'd20, 5'd31);
        #1;
        chk("mid_rst_clr_busy", 32'(clr_busy), 32'h0);
        chk("mid_rst_r20", rd_data[31:0], 32'h0);
        chk("mid_rst_r31", rd_data[63:32], 32'h0);
        tick();
        rst = 1'b0;
        wa(5'd6, 32'h00000066);
        sb_set_en = 1'b1; sb_set_addr = 5'd6;
        tick();
        idle_in();
        set_rd(5'd6, 5'd6);
        #1;
        chk("post_rst_r6", rd_data[31:0], 32'h00000066);
        chk("post_rst_pend_r6", 32'(rd_busy[0]), 32'h1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("reclr_pend_r6", 32'(rd_busy[0]), 32'h0);
        cnt = 0;
        for (int k = 0; k < 100 && clr_busy; k++) begin
            cnt++;
            tick();
        end
        chk("reclr_cycles", 32'(cnt), 32'd31);
        #1;
        chk("reclr_r6", rd_data[31:0], 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, successor to the single-write 32x32 regfile in the CPU datapath. It adds:
- a configurable number of combinational read ports;
- two write ports (port A for ALU writeback, port B for load writeback) with same-cycle write-to-read bypass;
- a per-register pending-load scoreboard;
- a sequential clear engine that zeroes the whole file on request.

It sits between decode (reads, scoreboard set) and the writeback stage.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see array only

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data
- rd_busy  out  NUM_RD  scoreboard pending bit per read port
- wa_en, wa_addr, wa_data  in  1/ADDR_W/DATA_W  write port A (ALU)
- wb_en, wb_addr, wb_data  in  1/ADDR_W/DATA_W  write port B (load); a write here also clears that register's pending bit
- sb_set_en, sb_set_addr  in  1/ADDR_W  mark register pending (load issued)
- clr_req  in  1  start clear of whole file (single-cycle pulse)
- clr_busy  out  1  clear engine active

## Operation

Register 0:
- Reads 0 on every port, always.
- Writes and sb_set to address 0 are dropped.

Writes:
- Commit at posedge when enabled.
- wa and wb to the same address in the same cycle: port B wins.

Reads:
- Combinational.
- With BYPASS=1, priority is: wb match > wa match > array.
- Address 0 is never bypassed.

Scoreboard (DEPTH bits):
- sb_set sets the bit.
- A wb write clears the bit.
- Set and clear of the same address in the same cycle: set wins.
- rd_busy[i] = pend[rd_addr_i].
- With BYPASS=1, rd_busy[i] is masked to 0 when wb_en and wb_addr == rd_addr_i.

Clear FSM, states IDLE and CLEAR:
- IDLE -> CLEAR on clr_req: counter loads 1 and all pending bits are cleared.
- CLEAR: one register zeroed per cycle at the counter address, then the counter increments. After register DEPTH-1 is zeroed, return to IDLE.
- In CLEAR, wa/wb/sb_set are ignored (dropped, not queued).
- In CLEAR, reads return array contents with no bypass.
- clr_req while in CLEAR is ignored.

Reset:
- All registers 0, all pending bits 0, FSM IDLE, counter 0.
- Outputs: rd_data 0, rd_busy 0, clr_busy 0.
- Reset asserted mid-clear aborts the clear and completes the zeroing instantly.

## Timing
- Read latency 0 (combinational from rd_addr, write inputs and array).
- Write visible in the array from the cycle after the enabling edge.
- clr_req sampled at edge N:
  - clr_busy is high from after edge N until after edge N+DEPTH-1.
  - Register k is zeroed at edge N+k.
  - The total clear takes DEPTH-1 cycles, which is 31 at the default ADDR_W.
- Pending bit set at edge N is visible on rd_busy after edge N.
- clr_busy is a registered output.

## Structure
- Package regfile_pkg holds:
  - the clear FSM state enum (IDLE, CLEAR);
  - the function deriving DEPTH from ADDR_W.
- Sub-module regfile_clr_fsm contains:
  - the state and counter;
  - outputs clr_busy, clr_we, clr_addr and a one-cycle sb_flush pulse.
- The array, write arbitration, bypass mux and scoreboard stay in regfile_mp.
- Read ports are built with a generate loop over NUM_RD.

## Test plan
- Reset then read: assert rst, read every address on all ports -> 0; rd_busy=0, clr_busy=0.
- Dual write collision: wa_en/wb_en both to r5, wa_data=0x11111111, wb_data=0x22222222 -> next cycle r5 reads 0x22222222. Writes to r0 -> r0 still reads 0.
- Bypass: BYPASS=1, wa write r7=0xDEADBEEF while rd_addr0=7 -> same cycle rd_data0=0xDEADBEEF. With BYPASS=0 -> old value until the next cycle.
- Scoreboard:
  - sb_set r9 -> rd_busy=1 next cycle;
  - wb write r9 -> rd_busy=0 in the same cycle (bypass) and afterwards;
  - sb_set r9 together with a wb write to r9 -> bit stays 1.
- Clear: fill r1..r31 with a nonzero value, set pending on r3, pulse clr_req ->
  - clr_busy high for exactly 31 cycles;
  - r3 pending clear the cycle after the request;
  - a wa write to r4 during the clear is dropped;
  - all registers read 0 afterwards.
- Reset mid-clear: pulse clr_req, assert rst at cycle 10 -> clr_busy=0 immediately, all registers 0, a later clr_req works normally.
